// File: rtl/button_event_gen.sv
// Turns the debounced button level into one-cycle press / release / long-press /
// auto-repeat pulses, plus a held level. All outputs are registered.
module button_event_gen #(
  parameter int LONG_PRESS_TIME = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [1:0] dbg_state_o
);

  localparam int MAX_T = (LONG_PRESS_TIME > REPEAT_PERIOD) ? LONG_PRESS_TIME : REPEAT_PERIOD;
  localparam int CW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;
  localparam logic [CW-1:0] LP_LAST  = CW'(LONG_PRESS_TIME - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    PRESSED      = 2'd2,
    HELD         = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held_q, held_d;

  // State register; outputs are registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= WAIT_RELEASE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Next state and counter. The counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_RELEASE: begin
        cnt_d = '0;
        if (!btn) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (btn) state_d = PRESSED;
      end
      PRESSED: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LP_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse decode; a release on the same edge suppresses long/repeat naturally
  // because those branches require btn = 1.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE:    press_d = btn;
      PRESSED: begin
        release_d = !btn;
        long_d    = btn && (cnt_q == LP_LAST);
      end
      HELD: begin
        release_d = !btn;
        repeat_d  = btn && repeat_en && (cnt_q == REP_LAST);
      end
      default: ;
    endcase
    held_d = (state_d == PRESSED) || (state_d == HELD);
  end

  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign repeat_pulse     = repeat_q;
  assign held             = held_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_PRESS_TIME = 5, REPEAT_PERIOD = 3.
// Expected pulses are queued as {edge, kind} words and matched by a monitor.
module tb_button_event_gen;

  localparam int LPT = 5;
  localparam int RP  = 3;
  localparam logic [3:0] K_PRESS = 4'b0001;
  localparam logic [3:0] K_REL   = 4'b0010;
  localparam logic [3:0] K_LONG  = 4'b0100;
  localparam logic [3:0] K_REP   = 4'b1000;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       repeat_en;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [1:0] dbg_state;

  logic [31:0] exp_q[$];
  int          edge_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic        mon_en   = 1'b0;
  int          k;

  button_event_gen #(
    .LONG_PRESS_TIME(LPT),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn             (btn),
    .repeat_en       (repeat_en),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse),
    .held            (held),
    .dbg_state_o     (dbg_state)
  );

  // Clock and edge numbering: after posedge n, edge_cnt == n.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every pulse seen must match the head of the expected queue.
  always @(negedge clk) begin
    logic [3:0]  kinds;
    logic [31:0] act;
    logic [31:0] expw;
    kinds = {repeat_pulse, long_press_pulse, release_pulse, press_pulse};
    if (mon_en && (kinds != 4'b0000)) begin
      act = {edge_cnt[27:0], kinds};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual edge %0d kinds %b required none",
                 edge_cnt, kinds);
      end else begin
        expw = exp_q.pop_front();
        if (act !== expw) begin
          errors++;
          $display("FAIL pulse_match actual edge %0d kinds %b required edge %0d kinds %b",
                   edge_cnt, kinds, expw[31:4], expw[3:0]);
        end
      end
    end
  end

  task automatic push(input logic [3:0] kind, input int e);
    exp_q.push_back({e[27:0], kind});
  endtask

  // Drive inputs for n edges; returns at #2 after the last of them.
  task automatic hold(input logic b, input logic r, input logic rs, input int n);
    for (int i = 0; i < n; i++) begin
      btn       = b;
      repeat_en = r;
      rst       = rs;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, expv);
    end
  endtask

  task automatic drain(input string name);
    hold(1'b0, 1'b0, 1'b1, 4);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    btn = 1'b1; repeat_en = 1'b0; rst = 1'b0;

    // Reset with the button held: nothing until it is released and pressed again.
    hold(1'b1, 1'b0, 1'b0, 3);
    chk("rst_press",   {31'd0, press_pulse},      0);
    chk("rst_release", {31'd0, release_pulse},    0);
    chk("rst_long",    {31'd0, long_press_pulse}, 0);
    chk("rst_repeat",  {31'd0, repeat_pulse},     0);
    chk("rst_held",    {31'd0, held},             0);
    chk("rst_state",   {30'd0, dbg_state},        0);
    mon_en = 1'b1;
    hold(1'b1, 1'b0, 1'b1, 4);
    chk("wait_rel_held", {31'd0, held}, 0);
    hold(1'b0, 1'b0, 1'b1, 1);
    // Back-to-back press/release/press/release on consecutive edges.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_REL, k + 1); push(K_PRESS, k + 2); push(K_REL, k + 3);
    hold(1'b1, 1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 1'b1, 1);
    hold(1'b1, 1'b0, 1'b1, 1);
    hold(1'b0, 1'b0, 1'b1, 1);
    drain("after_b2b");

    // Short press: held exactly 3 cycles.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_REL, k + 3);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 1'b0, 1'b1, 1);
      chk("short_held_hi", {31'd0, held}, 1);
    end
    hold(1'b0, 1'b0, 1'b1, 1);
    chk("short_held_lo", {31'd0, held}, 0);
    drain("after_short");

    // Long press with repeat enabled.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_LONG, k + LPT);
    push(K_REP, k + LPT + RP); push(K_REP, k + LPT + 2 * RP); push(K_REP, k + LPT + 3 * RP);
    push(K_REL, k + 15);
    hold(1'b1, 1'b1, 1'b1, 15);
    chk("long_held_hi", {31'd0, held}, 1);
    hold(1'b0, 1'b1, 1'b1, 1);
    chk("long_held_lo", {31'd0, held}, 0);
    drain("after_long_rep");

    // Repeat disabled, then enabled from edge k+9: first repeat at k+11.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_LONG, k + 5); push(K_REP, k + 11); push(K_REL, k + 13);
    hold(1'b1, 1'b0, 1'b1, 9);
    hold(1'b1, 1'b1, 1'b1, 4);
    hold(1'b0, 1'b1, 1'b1, 1);
    drain("after_rep_dis");

    // Release on the long-press edge: release only.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_REL, k + 5);
    hold(1'b1, 1'b0, 1'b1, 5);
    hold(1'b0, 1'b0, 1'b1, 1);
    drain("after_long_coll");

    // Release on a repeat edge: release only.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_LONG, k + 5); push(K_REL, k + 8);
    hold(1'b1, 1'b1, 1'b1, 8);
    hold(1'b0, 1'b1, 1'b1, 1);
    drain("after_rep_coll");

    // Reset mid-HELD: everything drops, no release pulse afterwards.
    k = edge_cnt + 1;
    push(K_PRESS, k); push(K_LONG, k + 5);
    hold(1'b1, 1'b1, 1'b1, 7);
    hold(1'b1, 1'b1, 1'b0, 1);
    chk("midrst_press",   {31'd0, press_pulse},      0);
    chk("midrst_release", {31'd0, release_pulse},    0);
    chk("midrst_long",    {31'd0, long_press_pulse}, 0);
    chk("midrst_repeat",  {31'd0, repeat_pulse},     0);
    chk("midrst_held",    {31'd0, held},             0);
    hold(1'b1, 1'b1, 1'b1, 4);
    chk("midrst_wait_held", {31'd0, held}, 0);
    hold(1'b0, 1'b1, 1'b1, 1);
    drain("after_midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
